// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-to-UART drain stage.
// Latency: n/a (types, constants and width helpers only).
// Backpressure: n/a.
package fifo_uart_pkg;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, START, DATA, STOP} state_t;

   localparam int DEF_DEPTH        = 10;
   localparam int DEF_DATA_W       = 8;
   localparam int DEF_CLKS_PER_BIT = 16;

   // Width needed to hold an occupancy of 0..depth.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width of a counter running 0..cpb-1; never narrower than one bit.
   function automatic int baud_width(input int cpb);
      return (cpb < 2) ? 1 : $clog2(cpb);
   endfunction

   localparam int OCC_W  = occ_width(DEF_DEPTH);
   localparam int BAUD_W = baud_width(DEF_CLKS_PER_BIT);

   // Line levels of the UART pin.
   localparam logic IDLE_LVL  = 1'b1;
   localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Bundle between the FIFO read port, the FIFO write strobe tap and the TX pin.
// Latency: n/a (wires only).
// Backpressure: none; the drain stage paces reads by its shadow occupancy.
interface fifo_uart_tx_if
   import fifo_uart_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int DATA_W = DEF_DATA_W
);

   localparam int OCC_BITS = occ_width(DEPTH);

   logic                fifo_wr;
   logic                fifo_rd;
   logic [DATA_W-1:0]   fifo_dout;
   logic                tx;
   logic                busy;
   logic [OCC_BITS-1:0] occ;

   // FIFO / board side: drives the write tap and read data, observes the line.
   modport master (
      output fifo_wr, fifo_dout,
      input  fifo_rd, tx, busy, occ
   );

   // Drain stage side.
   modport slave (
      input  fifo_wr, fifo_dout,
      output fifo_rd, tx, busy, occ
   );

endinterface

// File: rtl/fifo_uart_tx_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Latency: bit_done is combinational from the count register.
// Backpressure: none; clr restarts the period on every FSM state entry.
module fifo_uart_baud_cnt
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic bit_done
);

   localparam int                  CNT_BITS = baud_width(CLKS_PER_BIT);
   localparam logic [CNT_BITS-1:0] LAST     = CNT_BITS'(CLKS_PER_BIT - 1);

   logic [CNT_BITS-1:0] cnt_q;

   assign bit_done = en && (cnt_q == LAST);

   // Advance within the current bit; restart on state entry, at terminal count and while not serialising.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr || !en || bit_done) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_BITS'(1);
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO and serialises each byte as an 8N1 UART frame, LSB first.
// Latency: fifo_wr to start-bit edge is 4 cycles; each frame is (DATA_W+2)*CLKS_PER_BIT cycles.
// Backpressure: pops only while shadow occupancy is non-zero; writes seen at full are not counted.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int DEPTH        = DEF_DEPTH,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input logic           clk,
   input logic           rst,
   fifo_uart_tx_if.slave bus
);

   localparam int OCC_BITS = occ_width(DEPTH);
   localparam int IDX_BITS = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_t              state_q, state_d;
   logic [OCC_BITS-1:0] occ_q;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [IDX_BITS-1:0] idx_q, idx_d;
   logic                tx_q, tx_d;
   logic                rd;
   logic                wr_eff;
   logic                bit_done;
   logic                baud_en;
   logic                baud_clr;

   // The FIFO drops writes while full, so only writes landing below DEPTH are counted.
   assign rd       = (state_q == FETCH);
   assign wr_eff   = bus.fifo_wr && (occ_q < OCC_BITS'(DEPTH));
   assign baud_en  = (state_q == START) || (state_q == DATA) || (state_q == STOP);
   assign baud_clr = (state_d != state_q);

   fifo_uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .en       (baud_en),
      .clr      (baud_clr),
      .bit_done (bit_done)
   );

   // Shadow occupancy: +1 per counted write, -1 per read, unchanged when both coincide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= '0;
      end else if (wr_eff && !rd) begin
         occ_q <= occ_q + OCC_BITS'(1);
      end else if (!wr_eff && rd) begin
         occ_q <= occ_q - OCC_BITS'(1);
      end
   end

   // FSM state, shift register, bit index and the registered line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= IDLE_LVL;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
      end
   end

   // Next state and datapath; tx is computed for the state being entered so the pin tracks the state.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      tx_d    = IDLE_LVL;

      case (state_q)
         IDLE: begin
            if (occ_q != '0) state_d = FETCH;
         end
         FETCH: begin
            state_d = WAIT;
         end
         WAIT: begin
            // Read data is registered in the FIFO and valid one cycle after the strobe.
            shift_d = bus.fifo_dout;
            state_d = START;
         end
         START: begin
            if (bit_done) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (bit_done) begin
               shift_d = shift_q >> 1;
               if (idx_q == IDX_BITS'(DATA_W - 1)) begin
                  state_d = STOP;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_BITS'(1);
               end
            end
         end
         STOP: begin
            if (bit_done) state_d = (occ_q != '0) ? FETCH : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      case (state_d)
         START:   tx_d = START_LVL;
         DATA:    tx_d = shift_d[0];
         default: tx_d = IDLE_LVL;
      endcase
   end

   assign bus.fifo_rd = rd;
   assign bus.tx      = tx_q;
   assign bus.busy    = (state_q != IDLE);
   assign bus.occ     = occ_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: a queue-based FIFO model feeds the DUT, a UART line decoder checks frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_uart_tx;
   import fifo_uart_pkg::*;

   localparam int DEPTH  = 10;
   localparam int DATA_W = 8;
   localparam int CPB    = 4;
   localparam int FRAME  = (DATA_W + 2) * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   int n_total = 0;
   int n_pass  = 0;

   fifo_uart_tx_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus();

   fifo_uart_tx #(
      .DEPTH        (DEPTH),
      .DATA_W       (DATA_W),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Environment: the real FIFO (queue), plus the scoreboard of bytes it accepted.
   logic [7:0] wr_data;
   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] rx_log[$];
   int         starts[$];
   int         rd_cnt     = 0;
   int         frames_rx  = 0;
   int         last_start = 0;
   logic [9:0] last_frame;
   int         dut_peak   = 0;
   int         model_peak = 0;
   int         fsz;

   initial begin
      bus.fifo_dout = '0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            fifo_q.delete();
            exp_q.delete();
            bus.fifo_dout = '0;
         end else begin
            fsz = fifo_q.size();
            if (bus.fifo_rd) begin
               rd_cnt++;
               check("rd_when_empty", (fsz != 0), 1'b1);
               if (fsz != 0) bus.fifo_dout = fifo_q.pop_front();
            end
            if (bus.fifo_wr && fsz < DEPTH) begin
               fifo_q.push_back(wr_data);
               exp_q.push_back(wr_data);
            end
         end
      end
   end

   // Shadow occupancy must track the real FIFO fill every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("occ_track", bus.occ, fifo_q.size());
            if (int'(bus.occ) > dut_peak) dut_peak = int'(bus.occ);
            if (fifo_q.size() > model_peak) model_peak = fifo_q.size();
         end
      end
   end

   // UART line decoder: every cycle of every bit must hold one level.
   logic [9:0] m_fr;
   logic       m_stable;
   logic       m_abort;
   int         m_start;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus.tx === 1'b0) begin
            m_start  = cyc;
            m_abort  = 1'b0;
            m_stable = 1'b1;
            m_fr     = '0;
            for (int i = 0; i < FRAME; i++) begin
               if (i != 0) @(negedge clk);
               if (rst) begin
                  m_abort = 1'b1;
                  break;
               end
               if (i % CPB == 0) m_fr[i / CPB] = bus.tx;
               else if (bus.tx !== m_fr[i / CPB]) m_stable = 1'b0;
            end
            if (!m_abort) begin
               starts.push_back(m_start);
               last_start = m_start;
               last_frame = m_fr;
               rx_log.push_back(m_fr[8:1]);
               check("bit_stable", m_stable, 1'b1);
               check("stop_bit", m_fr[9], 1'b1);
               if (exp_q.size() == 0) check("frame_unexpected", 1'b1, 1'b0);
               else check("frame_data", m_fr[8:1], exp_q.pop_front());
               frames_rx++;
            end
         end
      end
   end

   task automatic put(input logic [7:0] b);
      bus.fifo_wr = 1'b1;
      wr_data     = b;
      @(negedge clk);
      bus.fifo_wr = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      int k;
      k = 0;
      while (frames_rx < target && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("frame_wait", (frames_rx >= target), 1'b1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not complete, %0d/%0d so far", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   int         wc, f0, r0, s0, li, k;
   logic [9:0] exp_line;
   logic [7:0] exp_list[12];

   initial begin
      bus.fifo_wr = 1'b0;
      wr_data     = '0;
      rst         = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx", bus.tx, 1'b1);
      check("rst_rd", bus.fifo_rd, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_occ", bus.occ, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single byte: latency, line pattern, one read, busy drops after the stop bit.
      f0 = frames_rx; r0 = rd_cnt; wc = cyc;
      put(8'hA5);
      while (cyc < wc + 4 + FRAME - 1) @(negedge clk);
      check("t1_busy_in_stop", bus.busy, 1'b1);
      @(negedge clk);
      check("t1_busy_after", bus.busy, 1'b0);
      check("t1_tx_after", bus.tx, 1'b1);
      wait_frames(f0 + 1);
      check("t1_latency", last_start - wc, 4);
      exp_line = {1'b1, 8'hA5, 1'b0};
      check("t1_line", last_frame, exp_line);
      check("t1_rd_pulses", rd_cnt - r0, 1);
      check("t1_occ", bus.occ, 0);

      // Back-to-back: FETCH/WAIT give exactly two idle cycles between frames.
      repeat (5) @(negedge clk);
      dut_peak = 0; model_peak = 0;
      f0 = frames_rx; r0 = rd_cnt; s0 = starts.size();
      put(8'h00); put(8'hFF); put(8'h3C);
      wait_frames(f0 + 3);
      check("t2_rd_pulses", rd_cnt - r0, 3);
      check("t2_gap01", starts[s0 + 1] - starts[s0], FRAME + 2);
      check("t2_gap12", starts[s0 + 2] - starts[s0 + 1], FRAME + 2);
      // The first read overlaps the third write, so occupancy tops out one below the burst length.
      check("t2_peak", dut_peak, model_peak);

      // Random bytes with random spacing.
      repeat (5) @(negedge clk);
      f0 = frames_rx; r0 = rd_cnt;
      for (int i = 0; i < 8; i++) begin
         put(8'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 50)) @(negedge clk);
      end
      wait_frames(f0 + 8);
      check("rand_rd_pulses", rd_cnt - r0, 8);

      // Overflow, then coincident write+read at full and at half.
      repeat (5) @(negedge clk);
      f0 = frames_rx; r0 = rd_cnt; li = rx_log.size();
      put(8'hEE);
      repeat (5) @(negedge clk);
      check("t3_busy", bus.busy, 1'b1);
      for (int i = 1; i <= 12; i++) put(8'(i));
      check("t3_occ_sat", bus.occ, DEPTH);
      k = 0;
      while (!bus.fifo_rd && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("t3_fetch_seen", bus.fifo_rd, 1'b1);
      check("t3_occ_full_fetch", bus.occ, DEPTH);
      put(8'h77);
      check("t3_occ_wr_rd_full", bus.occ, DEPTH - 1);
      k = 0;
      while (!(bus.fifo_rd && bus.occ == 5) && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check("t3_fetch_at5", bus.fifo_rd && bus.occ == 5, 1'b1);
      put(8'h55);
      check("t3_occ_wr_rd_mid", bus.occ, 5);
      wait_frames(f0 + 12);
      check("t3_rd_pulses", rd_cnt - r0, 12);
      exp_list[0] = 8'hEE;
      for (int i = 1; i <= 10; i++) exp_list[i] = 8'(i);
      exp_list[11] = 8'h55;
      check("t3_frames", rx_log.size() - li, 12);
      for (int i = 0; i < 12; i++) begin
         if (li + i < rx_log.size()) check("t3_order", rx_log[li + i], exp_list[i]);
      end

      // Reset during data bit 3 with two bytes queued.
      repeat (5) @(negedge clk);
      wc = cyc;
      put(8'h5A); put(8'h11); put(8'h22);
      while (cyc < wc + 4 + 4 * CPB + 1) @(negedge clk);
      check("t4_busy_pre", bus.busy, 1'b1);
      check("t4_occ_pre", bus.occ, 2);
      rst = 1'b1;
      #1;
      check("t4_tx_rst", bus.tx, 1'b1);
      check("t4_occ_rst", bus.occ, 0);
      check("t4_busy_rst", bus.busy, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      f0 = frames_rx;
      put(8'h81);
      wait_frames(f0 + 1);
      exp_line = {1'b1, 8'h81, 1'b0};
      check("t4_line", last_frame, exp_line);
      repeat (FRAME + 10) @(negedge clk);
      check("t4_frames", frames_rx - f0, 1);

      // Idle stability.
      r0 = rd_cnt;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         check("idle_tx", bus.tx, 1'b1);
         check("idle_rd", bus.fifo_rd, 1'b0);
         check("idle_busy", bus.busy, 1'b0);
      end
      check("idle_rd_pulses", rd_cnt - r0, 0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
